pia_porta_handshake_tx: RTL and testbench
=========================================

// Module: pia_porta_handshake_tx
// PURPOSE
//  Peripheral-side transmitter for the 6520 port-A read handshake: queues bytes from
//  a host-side source, presents each on the PIA paIn bus, pulses CA1 (data ready) and
//  waits for the PIA to drop CA2 (CPU has read ORA). Models keyboard/parallel input
//  devices feeding pia6520 on the AIM65 board; sits between device logic and the PIA.
// PARAMETERS
//  FIFO_AW        2     log2 of byte FIFO depth (depth = 4)
//  SETUP_CYCLES   2     clocks pa_out is stable before CA1 active edge (>=1)
//  STROBE_CYCLES  2     clocks ca1_out held at active level (>=1)
//  TIMEOUT_CYCLES 1024  max clocks in WAIT_ACK before byte is dropped (>=2)
//  CA1_ACTIVE     0     active level of ca1_out strobe (0 = falling edge active)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  wr_en        in   1  push wr_data into FIFO (ignored when full)
//  wr_data      in   8  byte to send
//  full         out  1  FIFO full
//  level        out  FIFO_AW+1  bytes queued (excludes byte in flight)
//  pa_out       out  8  drives PIA paIn
//  ca1_out      out  1  drives PIA ca1_in
//  ca2_in       in   1  from PIA ca2_out (asynchronous to this block's use; synchronised)
//  busy         out  1  high in any state except IDLE
//  err_clr      in   1  clears sticky error flags
//  timeout_err  out  1  sticky: a byte was dropped for lack of acknowledge
//  overflow_err out  1  sticky: wr_en seen while full
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, level=0, full=0, pa_out=8'h00,
//   ca1_out=~CA1_ACTIVE, busy=0, both errors 0, state IDLE, counters 0, sync flops 1.
//   Reset mid-transfer abandons the byte; no CA1 edge is produced on release.
//  ca2_in passes a 2-flop synchroniser; ack = synced CA2 falling edge (1->0).
//  FIFO: push when wr_en & ~full; pop only in IDLE->SETUP. Push while full is dropped
//   and sets overflow_err, even if a pop occurs the same cycle. Push+pop same cycle
//   when not full: level unchanged. Pointers wrap modulo 2^FIFO_AW.
//  States:
//   IDLE:     if level!=0 -> pop, pa_out<=head byte, go SETUP (busy next cycle).
//   SETUP:    hold SETUP_CYCLES clocks, then ca1_out<=CA1_ACTIVE, go STROBE.
//   STROBE:   hold STROBE_CYCLES clocks, then ca1_out<=~CA1_ACTIVE, go WAIT_ACK.
//   WAIT_ACK: ack -> go IDLE; else count; at TIMEOUT_CYCLES clocks set timeout_err,
//             go IDLE (byte dropped). Ack in same cycle as timeout wins (no error).
//   Acks outside WAIT_ACK are ignored (edge detector still tracks CA2).
//  pa_out holds the last byte until the next pop; never changes in SETUP..WAIT_ACK.
//  Minimum byte period = 1+SETUP+STROBE+ack latency (2 sync + 1 edge) clocks.
//  err_clr clears both sticky flags; a same-cycle set event wins over clear.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1 Reset: assert reset mid-STROBE -> ca1_out=1 and pa_out=00 immediately, busy=0.
//  2 Push 8'hA5, drop ca2_in 6 clk after ca1 rising edge -> pa_out=A5 1 clk after push
//    +1, ca1 low 2 clk then high 2 clk, busy clears 3 clk after ca2 fall.
//  3 Push 5 bytes 01..05 back-to-back -> full after 4th, 05 dropped, overflow_err=1;
//    with acks, 01..04 delivered in order, level counts 3,2,1,0.
//  4 No ack for byte 3C -> timeout_err=1 exactly TIMEOUT_CYCLES clk into WAIT_ACK,
//    next queued byte then sent; err_clr -> timeout_err=0.
//  5 CA2 falls during SETUP only -> ignored, block waits; later fall in WAIT_ACK completes.
//  6 Ack on final timeout cycle -> timeout_err stays 0; err_clr with overflow same
//    cycle -> overflow_err=1.

Source files
------------

// File: rtl/pia_porta_handshake_tx.sv
// Peripheral-side transmitter for the 6520 port-A read handshake: buffers bytes,
// presents each on pa_out, strobes CA1 and waits for the PIA to drop CA2.
module pia_porta_handshake_tx #(
  parameter int   FIFO_AW        = 2,
  parameter int   SETUP_CYCLES   = 2,
  parameter int   STROBE_CYCLES  = 2,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic CA1_ACTIVE     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic [FIFO_AW:0] level,
  output logic [7:0]       pa_out,
  output logic             ca1_out,
  input  logic             ca2_in,
  output logic             busy,
  input  logic             err_clr,
  output logic             timeout_err,
  output logic             overflow_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int MAX_HS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0]      CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0]      STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0]      TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0]   LVL_ZERO    = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   LVL_ONE     = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   DEPTH_V     = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE     = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_STROBE   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [CW-1:0]      cnt_r, cnt_nx_s;
  logic               ca1_r, ca1_nx_s;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r, count_nx_s;
  logic               full_r, busy_r, terr_r, oerr_r;
  logic [7:0]         pa_r;
  logic               ca2_meta_r, ca2_sync_r, ca2_prev_r;
  logic               ack_s, push_s, ovf_s, pop_s, tmo_s;

  assign ack_s  = ca2_prev_r & ~ca2_sync_r;
  assign push_s = wr_en & ~full_r;
  assign ovf_s  = wr_en & full_r;

  // Next-state and handshake sequencing
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    ca1_nx_s   = ca1_r;
    pop_s      = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != LVL_ZERO) begin
          pop_s      = 1'b1;
          state_nx_s = ST_SETUP;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          ca1_nx_s   = CA1_ACTIVE;
          state_nx_s = ST_STROBE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          ca1_nx_s   = ~CA1_ACTIVE;
          state_nx_s = ST_WAIT_ACK;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_ACK: begin
        // An acknowledge on the final timeout cycle takes precedence
        if (ack_s) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == TMO_LAST) begin
          tmo_s      = 1'b1;
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
        ca1_nx_s   = ~CA1_ACTIVE;
      end
    endcase
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_nx_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + LVL_ONE;
      2'b01:   count_nx_s = count_r - LVL_ONE;
      default: count_nx_s = count_r;
    endcase
  end

  // Control, output and synchroniser registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      ca1_r      <= ~CA1_ACTIVE;
      pa_r       <= 8'h00;
      busy_r     <= 1'b0;
      count_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      terr_r     <= 1'b0;
      oerr_r     <= 1'b0;
      ca2_meta_r <= 1'b1;
      ca2_sync_r <= 1'b1;
      ca2_prev_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      ca1_r      <= ca1_nx_s;
      busy_r     <= (state_nx_s != ST_IDLE);
      count_r    <= count_nx_s;
      full_r     <= (count_nx_s == DEPTH_V);
      ca2_meta_r <= ca2_in;
      ca2_sync_r <= ca2_meta_r;
      ca2_prev_r <= ca2_sync_r;
      // A set event in the same cycle as err_clr leaves the flag set
      terr_r     <= tmo_s | (terr_r & ~err_clr);
      oerr_r     <= ovf_s | (oerr_r & ~err_clr);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        pa_r     <= mem_r[rd_ptr_r];
      end
    end
  end

  // Byte storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign full         = full_r;
  assign level        = count_r;
  assign pa_out       = pa_r;
  assign ca1_out      = ca1_r;
  assign busy         = busy_r;
  assign timeout_err  = terr_r;
  assign overflow_err = oerr_r;

endmodule

// File: tb/tb_pia_porta_handshake_tx.sv
// Bench for pia_porta_handshake_tx: directed handshake scenarios then random traffic,
// every cycle compared against a queue/timestamp model of the transmitter.
module tb_pia_porta_handshake_tx;

  localparam int   AW    = 2;
  localparam int   DEPTH = 4;
  localparam int   SC    = 2;
  localparam int   STC   = 2;
  localparam int   TC    = 24;
  localparam logic ACT   = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [AW:0]   level;
  logic [7:0]    pa_out;
  logic          ca1_out;
  logic          ca2_in;
  logic          busy;
  logic          err_clr;
  logic          timeout_err;
  logic          overflow_err;

  always #5 clk = ~clk;

  pia_porta_handshake_tx #(
    .FIFO_AW(AW), .SETUP_CYCLES(SC), .STROBE_CYCLES(STC),
    .TIMEOUT_CYCLES(TC), .CA1_ACTIVE(ACT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .pa_out(pa_out), .ca1_out(ca1_out),
    .ca2_in(ca2_in), .busy(busy), .err_clr(err_clr),
    .timeout_err(timeout_err), .overflow_err(overflow_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of waiting bytes plus timestamps of the byte in flight
  logic [7:0] m_q[$];
  int         m_cyc;
  bit         m_busy;
  int         m_tpop;
  logic [7:0] m_pa;
  logic       m_ca1, m_terr, m_oerr;
  logic       h1, h2, h3;   // ca2 samples taken 1, 2 and 3 edges ago
  logic       ca2_v;

  task automatic model_reset();
    m_q.delete();
    m_cyc = 0; m_busy = 1'b0; m_tpop = 0; m_pa = 8'h00;
    m_ca1 = ~ACT; m_terr = 1'b0; m_oerr = 1'b0;
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
  endtask

  task automatic model_step();
    int   w0;
    int   sz;
    logic ack, tset, oset;
    m_cyc++;
    ack  = h3 & ~h2;
    tset = 1'b0;
    oset = 1'b0;
    sz   = m_q.size();
    if (m_busy) begin
      w0 = m_tpop + SC + STC;
      if (m_cyc == m_tpop + SC) m_ca1 = ACT;
      if (m_cyc == w0) m_ca1 = ~ACT;
      if (m_cyc > w0) begin
        if (ack) m_busy = 1'b0;
        else if (m_cyc == w0 + TC) begin
          m_busy = 1'b0;
          tset = 1'b1;
        end
      end
    end else if (sz > 0) begin
      m_pa   = m_q.pop_front();
      m_busy = 1'b1;
      m_tpop = m_cyc;
    end
    if (wr_en) begin
      if (sz == DEPTH) oset = 1'b1;
      else m_q.push_back(wr_data);
    end
    m_terr = tset | (m_terr & ~err_clr);
    m_oerr = oset | (m_oerr & ~err_clr);
    h3 = h2; h2 = h1; h1 = ca2_in;
  endtask

  task automatic check_outputs();
    check("pa_out", {24'd0, pa_out}, {24'd0, m_pa});
    check("ca1_out", {31'd0, ca1_out}, {31'd0, m_ca1});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("level", {29'd0, level}, 32'(m_q.size()));
    check("full", {31'd0, full}, {31'd0, (m_q.size() == DEPTH)});
    check("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    check("overflow_err", {31'd0, overflow_err}, {31'd0, m_oerr});
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic clr);
    @(negedge clk);
    wr_en = w; wr_data = d; err_clr = clr; ca2_in = ca2_v;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Acts as the PIA: drops CA2 'delay' edges into WAIT_ACK (never if negative)
  task automatic serve(input int n, input int delay);
    for (int i = 0; i < n; i++) begin
      if (!m_busy) ca2_v = 1'b1;
      else if (delay >= 0 && (m_cyc + 1) == m_tpop + SC + STC + delay) ca2_v = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0; ca2_in = 1'b1; ca2_v = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    check("rst_pa", {24'd0, pa_out}, 32'h00);
    check("rst_ca1", {31'd0, ca1_out}, 32'd1);
    check("rst_level", {29'd0, level}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Reset in the middle of the CA1 strobe
    cycle(1'b1, 8'h77, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    check("t1_strobe_active", {31'd0, ca1_out}, 32'd0);
    #3 reset = 1'b1;
    #1;
    check("t1_rst_ca1", {31'd0, ca1_out}, 32'd1);
    check("t1_rst_pa", {24'd0, pa_out}, 32'h00);
    check("t1_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (5) cycle(1'b0, 8'h00, 1'b0);

    // Single byte acknowledged 6 clocks after CA1 returns high
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t2_pa", {24'd0, pa_out}, 32'hA5);
    serve(30, 6);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // Byte in flight, then 01..05 into a 4-deep FIFO; 3C times out
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_ovf", {31'd0, overflow_err}, 32'd1);
    for (int i = 0; i < 100 && m_busy; i++) serve(1, -1);
    check("t4_timeout", {31'd0, timeout_err}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t4_clr", {31'd0, timeout_err}, 32'd0);
    serve(80, 3);
    check("t3_drained", {29'd0, level}, 32'd0);

    // CA2 falls during SETUP only, then again in WAIT_ACK
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    ca2_v = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    ca2_v = 1'b1;
    repeat (7) cycle(1'b0, 8'h00, 1'b0);
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    ca2_v = 1'b0;
    serve(10, -1);
    check("t5_done", {31'd0, busy}, 32'd0);

    // Ack on the last timeout cycle; overflow coinciding with err_clr
    cycle(1'b1, 8'h6E, 1'b0);
    serve(40, TC - 2);
    check("t6_no_timeout", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h11 * 8'(i + 1), 1'b0);
    cycle(1'b1, 8'h66, 1'b1);
    check("t6_ovf_wins", {31'd0, overflow_err}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t6_ovf_clr", {31'd0, overflow_err}, 32'd0);
    serve(100, 2);

    // Random traffic, random CA2 activity and random clears
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7, 0) == 0) ca2_v = ~ca2_v;
      cycle(($urandom_range(3, 0) == 0), 8'($urandom), ($urandom_range(15, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
